// File: rtl/data_bus_interconnect.sv
// N-master x M-slave data bus interconnect: round-robin arbitration, tag decode
// on a fixed address field, and an in-order tagged read-response pipeline.
module data_bus_interconnect #(
  parameter int NUM_MASTERS = 2,
  parameter int NUM_SLAVES  = 5,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int SEL_MSB     = 31,
  parameter int SEL_LSB     = 28,
  parameter logic [NUM_SLAVES*(SEL_MSB-SEL_LSB+1)-1:0] SLAVE_TAGS =
    {4'hE, 4'hD, 4'hC, 4'h1, 4'h0},
  parameter int RD_LATENCY  = 1
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_MASTERS-1:0]           m_req,
  input  logic [NUM_MASTERS*ADDR_W-1:0]    m_addr,
  input  logic [NUM_MASTERS*DATA_W-1:0]    m_wr_data,
  input  logic [NUM_MASTERS*DATA_W/8-1:0]  m_wr_en,
  output logic [NUM_MASTERS-1:0]           m_gnt,
  output logic [NUM_MASTERS-1:0]           m_rsp_valid,
  output logic [DATA_W-1:0]                m_rd_data,
  output logic                             m_err,
  output logic [NUM_SLAVES*ADDR_W-1:0]     s_address,
  output logic [NUM_SLAVES*DATA_W-1:0]     s_wr_data,
  output logic [NUM_SLAVES*DATA_W/8-1:0]   s_wr_en,
  input  logic [NUM_SLAVES*DATA_W-1:0]     s_rd_data
);

  localparam int TAG_W = SEL_MSB - SEL_LSB + 1;
  localparam int BE_W  = DATA_W / 8;
  localparam int MID_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int SID_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int LAST  = RD_LATENCY - 1;

  logic [MID_W-1:0]  rr_ptr_r;
  logic [MID_W-1:0]  gnt_idx_s;
  logic              gnt_any_s;
  logic [ADDR_W-1:0] sel_addr_s;
  logic [DATA_W-1:0] sel_data_s;
  logic [BE_W-1:0]   sel_be_s;
  logic              hit_s;
  logic [SID_W-1:0]  sid_s;

  logic [RD_LATENCY-1:0]            vld_r;
  logic [RD_LATENCY-1:0][MID_W-1:0] id_r;
  logic [RD_LATENCY-1:0][SID_W-1:0] sid_r;
  logic [RD_LATENCY-1:0]            unm_r;

  // Round-robin pick: first requester at or after rr_ptr, wrapping upward.
  always_comb begin
    gnt_any_s = 1'b0;
    gnt_idx_s = '0;
    m_gnt     = '0;
    if (reset) begin
      gnt_any_s = 1'b0;
    end else begin
      for (int off = 0; off < NUM_MASTERS; off++) begin
        if (!gnt_any_s && m_req[(int'(rr_ptr_r) + off) % NUM_MASTERS]) begin
          gnt_any_s = 1'b1;
          gnt_idx_s = MID_W'((int'(rr_ptr_r) + off) % NUM_MASTERS);
        end else begin
          gnt_any_s = gnt_any_s;
        end
      end
      if (gnt_any_s) begin
        m_gnt[gnt_idx_s] = 1'b1;
      end else begin
        m_gnt = '0;
      end
    end
  end

  assign sel_addr_s = m_addr[int'(gnt_idx_s)*ADDR_W +: ADDR_W];
  assign sel_data_s = m_wr_data[int'(gnt_idx_s)*DATA_W +: DATA_W];
  assign sel_be_s   = m_wr_en[int'(gnt_idx_s)*BE_W +: BE_W];

  // Route the winner to the lowest-indexed slave whose tag matches; others stay zero.
  always_comb begin
    hit_s     = 1'b0;
    sid_s     = '0;
    s_address = '0;
    s_wr_data = '0;
    s_wr_en   = '0;
    for (int k = 0; k < NUM_SLAVES; k++) begin
      if (gnt_any_s && !hit_s &&
          sel_addr_s[SEL_MSB:SEL_LSB] == SLAVE_TAGS[k*TAG_W +: TAG_W]) begin
        hit_s                         = 1'b1;
        sid_s                         = SID_W'(k);
        s_address[k*ADDR_W +: ADDR_W] = sel_addr_s;
        s_wr_data[k*DATA_W +: DATA_W] = sel_data_s;
        s_wr_en[k*BE_W +: BE_W]       = sel_be_s;
      end else begin
        hit_s = hit_s;
      end
    end
  end

  // Response tag pipeline and round-robin pointer advance.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr_r <= '0;
      vld_r    <= '0;
      id_r     <= '0;
      sid_r    <= '0;
      unm_r    <= '0;
    end else begin
      vld_r[0] <= gnt_any_s;
      id_r[0]  <= gnt_idx_s;
      sid_r[0] <= sid_s;
      unm_r[0] <= ~hit_s;
      for (int i = 1; i < RD_LATENCY; i++) begin
        vld_r[i] <= vld_r[i-1];
        id_r[i]  <= id_r[i-1];
        sid_r[i] <= sid_r[i-1];
        unm_r[i] <= unm_r[i-1];
      end
      if (gnt_any_s) begin
        rr_ptr_r <= MID_W'((int'(gnt_idx_s) + 1) % NUM_MASTERS);
      end else begin
        rr_ptr_r <= rr_ptr_r;
      end
    end
  end

  // Deliver the oldest response to its issuing master; unmapped returns zero data.
  always_comb begin
    m_rsp_valid = '0;
    m_rd_data   = '0;
    m_err       = 1'b0;
    if (vld_r[LAST]) begin
      m_rsp_valid[id_r[LAST]] = 1'b1;
      m_err                   = unm_r[LAST];
      if (unm_r[LAST]) begin
        m_rd_data = '0;
      end else begin
        m_rd_data = s_rd_data[int'(sid_r[LAST])*DATA_W +: DATA_W];
      end
    end else begin
      m_rsp_valid = '0;
    end
  end

endmodule
